// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage. It accepts one held load/store request,
// waits LATENCY cycles, performs the word access, then pulses Ready. It also raises
// Stall so the pipeline stays frozen while the access is outstanding.
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2 = 5,
    parameter int unsigned LATENCY    = 2   // legal range 1..15
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Req,
    input  logic        Wmem,
    input  logic [31:0] Addr,
    input  logic [31:0] Wdata,
    output logic [31:0] Rdata,
    output logic        Ready,
    output logic        Err,
    output logic        Stall
);

    localparam int unsigned Words = 1 << DEPTH_LOG2;
    localparam int unsigned AddrW = DEPTH_LOG2 + 2;

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [AddrW-1:0]      addr_q, addr_d;
    logic                  wmem_q, wmem_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;
    logic [31:0]           mem_q [Words];

    // Access performed on the edge that enters StDone
    logic                  acc_en;
    logic [AddrW-1:0]      acc_addr;
    logic                  acc_wmem;
    logic [31:0]           acc_wdata;
    logic                  acc_misaligned;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic                  mem_we;

    // Address bits above the memory size are ignored so accesses wrap
    logic unused_addr_hi;
    assign unused_addr_hi = ^Addr[31:AddrW];

    // Next-state logic: request capture, latency countdown and access decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wmem_d    = wmem_q;
        wdata_d   = wdata_q;
        acc_en    = 1'b0;
        acc_addr  = addr_q;
        acc_wmem  = wmem_q;
        acc_wdata = wdata_q;

        unique case (state_q)
            StIdle: begin
                if (Req) begin
                    addr_d  = Addr[AddrW-1:0];
                    wmem_d  = Wmem;
                    wdata_d = Wdata;
                    cnt_d   = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        // Single-cycle latency: access uses the live request on acceptance
                        state_d   = StDone;
                        acc_en    = 1'b1;
                        acc_addr  = Addr[AddrW-1:0];
                        acc_wmem  = Wmem;
                        acc_wdata = Wdata;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StDone;
                    acc_en  = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        acc_misaligned = (acc_addr[1:0] != 2'b00);
        acc_idx        = acc_addr[AddrW-1:2];
        mem_we         = acc_en & acc_wmem & ~acc_misaligned;
        ready_d        = acc_en;
        err_d          = acc_en & acc_misaligned;
        rdata_d        = rdata_q;
        if (acc_en && acc_misaligned) begin
            rdata_d = '0;
        end else if (acc_en && !acc_wmem) begin
            rdata_d = mem_q[acc_idx];
        end
    end

    // Control and output registers
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wmem_q  <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wmem_q  <= wmem_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Word storage, cleared by reset
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < Words; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

    assign Rdata = rdata_q;
    assign Ready = ready_q;
    assign Err   = err_q;
    assign Stall = ((state_q == StIdle) && Req) || (state_q == StWait);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LATENCY 2, 1, 4) with shared reset and
// data inputs. Stimulus pushes expected responses; a monitor pops them on each Ready pulse.
module tb_dmem_responder;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b1;
    logic [2:0]  req = '0;
    logic        wmem = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata [3];
    logic [2:0]  rdy, err, stall;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t q0[$], q1[$], q2[$];
    int   n_vec = 0;
    int   n_miss = 0;

    always #5 Clock = ~Clock;

    dmem_responder #(.DEPTH_LOG2(5), .LATENCY(2)) u_lat2 (
        .Clock(Clock), .Resetn(Resetn), .Req(req[0]), .Wmem(wmem), .Addr(addr), .Wdata(wdata),
        .Rdata(rdata[0]), .Ready(rdy[0]), .Err(err[0]), .Stall(stall[0])
    );
    dmem_responder #(.DEPTH_LOG2(5), .LATENCY(1)) u_lat1 (
        .Clock(Clock), .Resetn(Resetn), .Req(req[1]), .Wmem(wmem), .Addr(addr), .Wdata(wdata),
        .Rdata(rdata[1]), .Ready(rdy[1]), .Err(err[1]), .Stall(stall[1])
    );
    dmem_responder #(.DEPTH_LOG2(5), .LATENCY(4)) u_lat4 (
        .Clock(Clock), .Resetn(Resetn), .Req(req[2]), .Wmem(wmem), .Addr(addr), .Wdata(wdata),
        .Rdata(rdata[2]), .Ready(rdy[2]), .Err(err[2]), .Stall(stall[2])
    );

    task automatic chk(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_miss++;
            $display("FAIL %s dut%0d: got %h, want %h at %0t", name, d, act, want, $time);
        end
    endtask

    task automatic chk1(input string name, input int d, input logic act, input logic want);
        n_vec++;
        if (act !== want) begin
            n_miss++;
            $display("FAIL %s dut%0d: got %b, want %b at %0t", name, d, act, want, $time);
        end
    endtask

    task automatic push_exp(input int d, input logic [31:0] er, input logic ee);
        exp_t e;
        e.rdata = er;
        e.err   = ee;
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qpop(input int d);
        case (d)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Called at negedge+1 of an IDLE cycle: present the request and record its response
    task automatic issue(input int d, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee);
        wmem   = w;
        addr   = a;
        wdata  = wd;
        req[d] = 1'b1;
        push_exp(d, er, ee);
        #1 chk1("stall_accept", d, stall[d], 1'b1);
    endtask

    // Count cycles to Ready; scramble request inputs meanwhile, they must be ignored
    task automatic wait_ready(input int d, input int lat);
        int n = 0;
        bit seen = 0;
        while (!seen && n < 20) begin
            @(negedge Clock);
            #1;
            n++;
            if (rdy[d]) begin
                seen = 1;
            end else begin
                chk1("stall_wait", d, stall[d], 1'b1);
                addr  = 32'hFFFF_FFF3;
                wdata = $urandom;
                wmem  = ~wmem;
            end
        end
        chk("ready_latency", d, n, lat);
        if (seen) chk1("stall_done", d, stall[d], 1'b0);
    endtask

    task automatic xfer(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee,
                        input int lat);
        issue(d, w, a, wd, er, ee);
        wait_ready(d, lat);
        req[d] = 1'b0;
        @(negedge Clock);
        #1;
    endtask

    // Monitor: every Ready pulse is matched against the next expected response
    initial begin
        logic [2:0] prev_rdy;
        exp_t       e;
        prev_rdy = '0;
        forever begin
            @(negedge Clock);
            if (Resetn) begin
                for (int d = 0; d < 3; d++) begin
                    if (rdy[d]) begin
                        chk1("ready_single_cycle", d, prev_rdy[d], 1'b0);
                        if (qsize(d) == 0) begin
                            chk("spurious_ready", d, qsize(d), 1);
                        end else begin
                            e = qpop(d);
                            chk("rdata", d, rdata[d], e.rdata);
                            chk1("err", d, err[d], e.err);
                        end
                    end
                end
                prev_rdy = rdy;
            end else begin
                prev_rdy = '0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 Resetn = 1'b0;
        #11;
        for (int d = 0; d < 3; d++) begin
            chk("reset_rdata", d, rdata[d], 32'h0);
            chk1("reset_ready", d, rdy[d], 1'b0);
            chk1("reset_err", d, err[d], 1'b0);
            chk1("reset_stall", d, stall[d], 1'b0);
        end
        @(negedge Clock);
        #1 Resetn = 1'b1;
        @(negedge Clock);
        #1;

        // LATENCY=2: load from reset, store/load, wrap, misaligned store
        xfer(0, 1'b0, 32'h10, 32'h0,         32'h0,         1'b0, 2);
        xfer(0, 1'b1, 32'h08, 32'hDEADBEEF,  32'h0,         1'b0, 2);
        xfer(0, 1'b0, 32'h08, 32'h0,         32'hDEADBEEF,  1'b0, 2);
        xfer(0, 1'b0, 32'h88, 32'h0,         32'hDEADBEEF,  1'b0, 2);
        xfer(0, 1'b1, 32'h0A, 32'h12345678,  32'h0,         1'b1, 2);
        xfer(0, 1'b0, 32'h08, 32'h0,         32'hDEADBEEF,  1'b0, 2);

        // Back-to-back with Req held: second acceptance waits for the IDLE after DONE
        issue(0, 1'b1, 32'h14, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0);
        wait_ready(0, 2);
        wmem = 1'b0;
        addr = 32'h14;
        push_exp(0, 32'hA5A5A5A5, 1'b0);
        #1 chk1("stall_done_req_held", 0, stall[0], 1'b0);
        @(negedge Clock);
        #1;
        chk1("b2b_idle_ready", 0, rdy[0], 1'b0);
        chk1("b2b_idle_stall", 0, stall[0], 1'b1);
        wait_ready(0, 2);
        req[0] = 1'b0;
        @(negedge Clock);
        #1;

        // LATENCY=1 corner
        xfer(1, 1'b1, 32'h00, 32'h00000055, 32'h0,          1'b0, 1);
        xfer(1, 1'b0, 32'h00, 32'h0,        32'h00000055,   1'b0, 1);

        // LATENCY=4: give Rdata a nonzero value, then reset in the middle of a store
        xfer(2, 1'b1, 32'h0C, 32'h11111111, 32'h0,          1'b0, 4);
        xfer(2, 1'b0, 32'h0C, 32'h0,        32'h11111111,   1'b0, 4);
        wmem   = 1'b1;
        addr   = 32'h04;
        wdata  = 32'hCAFEF00D;
        req[2] = 1'b1;
        @(negedge Clock);
        #1;
        chk1("stall_pre_reset", 2, stall[2], 1'b1);
        Resetn = 1'b0;
        req[2] = 1'b0;
        #1;
        chk("midreset_rdata", 2, rdata[2], 32'h0);
        chk1("midreset_ready", 2, rdy[2], 1'b0);
        chk1("midreset_err", 2, err[2], 1'b0);
        chk1("midreset_stall", 2, stall[2], 1'b0);
        chk("midreset_rdata", 1, rdata[1], 32'h0);
        @(negedge Clock);
        #1 Resetn = 1'b1;
        @(negedge Clock);
        #1;
        xfer(2, 1'b0, 32'h04, 32'h0, 32'h0, 1'b0, 4);
        xfer(2, 1'b0, 32'h0C, 32'h0, 32'h0, 1'b0, 4);
        xfer(0, 1'b0, 32'h08, 32'h0, 32'h0, 1'b0, 2);
        xfer(1, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0, 1);

        repeat (3) @(negedge Clock);
        for (int d = 0; d < 3; d++) begin
            chk("queue_drain", d, qsize(d), 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the MEM stage's load/store requests.
- A request is held asserted; the block accepts it, waits a programmable number of cycles, performs the word access, then pulses Ready.
- It drives Stall so the pipeline freezes IF/ID/EXE/MEM while an access is outstanding.
- Register-array storage, one outstanding request at a time.

Parameters:
- DEPTH_LOG2, 5, log2 of word count (32 words of 32 bits).
- LATENCY, 2, cycles from acceptance edge to Ready pulse; legal range 1..15.

Ports:
- Clock  input  1  system clock, rising edge.
- Resetn  input  1  reset, asynchronous and active-low.
- Req  input  1  access request, held by requester until Ready.
- Wmem  input  1  1 = store, 0 = load; sampled at acceptance.
- Addr  input  32  byte address; sampled at acceptance.
- Wdata  input  32  store data; sampled at acceptance.
- Rdata  output  32  load data; valid while Ready=1, held afterwards.
- Ready  output  1  one-cycle completion pulse.
- Err  output  1  misaligned-access flag, coincident with Ready.
- Stall  output  1  combinational pipeline freeze.

Behaviour:
- Reset (Resetn=0, asynchronous):
  - State = IDLE; counter = 0; captured address, Wmem and Wdata = 0.
  - Rdata = 0, Ready = 0, Err = 0.
  - All memory words cleared to 0.
  - Reset during WAIT discards the pending access; no memory write occurs.
- FSM states IDLE, WAIT, DONE:
  - IDLE, Req=1 at an edge: capture Addr, Wmem, Wdata; counter = LATENCY-1. Next state is DONE if LATENCY=1, else WAIT.
  - WAIT: counter decrements each edge. On the edge where counter=1, go to DONE and perform the access on that same edge.
  - DONE: Ready=1 for exactly this cycle; next edge returns to IDLE unconditionally.
  - A Req seen in DONE is not accepted; it is accepted in the following IDLE cycle.
- Access rules:
  - Word index = captured Addr[DEPTH_LOG2+1:2]. Higher address bits are ignored, so addresses wrap modulo 4*2^DEPTH_LOG2 bytes.
  - Misaligned access (captured Addr[1:0] != 0): no write, Rdata is driven 0, and Err=1 together with Ready.
  - Store: mem[index] <= Wdata; Rdata is unchanged.
  - Load: Rdata <= mem[index]; Rdata keeps that value until the next load or misaligned completion.
  - When LATENCY=1, the access is performed on the acceptance edge itself.
- Timing: request accepted at edge T; Ready is high during the cycle after edge T+LATENCY-1, i.e. LATENCY cycles after acceptance.
- Stall = (state==IDLE & Req) | (state==WAIT). Stall is 0 in DONE, so the pipeline advances on the edge that ends the Ready cycle.
- Req deasserted mid-WAIT does not cancel the access; it completes and Ready pulses anyway.
- Wmem, Addr and Wdata changes after acceptance have no effect.
- Outputs Ready, Err and Rdata are registered; Stall is combinational from state and Req.

Test Plan:
- Reset then load, LATENCY=2:
  - Stimulus: reset; Req=1, Wmem=0, Addr=0x10.
  - Required: Stall=1 in acceptance cycle and WAIT cycle; Ready=1 two cycles after acceptance with Rdata=0x00000000, Err=0; Stall=0 in DONE.
- Store then load:
  - Stimulus: store 0xDEADBEEF at Addr=0x08, drop Req one cycle after Ready, then load Addr=0x08.
  - Required: Rdata=0xDEADBEEF with Ready; loading Addr=0x88 (wrap, DEPTH_LOG2=5) also returns 0xDEADBEEF.
- Misaligned store:
  - Stimulus: store 0x12345678 to Addr=0x0A.
  - Required: Ready=1 and Err=1 together, Rdata=0; a subsequent load of 0x08 still returns the prior value.
- Back-to-back requests:
  - Stimulus: Req held high across two consecutive requests.
  - Required: second acceptance occurs in the IDLE cycle after DONE; exactly one Ready pulse per request; Ready never high for 2 consecutive cycles.
- Reset mid-operation:
  - Stimulus: store 0xCAFEF00D to Addr=0x04 with LATENCY=4; assert Resetn=0 during WAIT.
  - Required: Ready, Err, Stall and Rdata go 0 immediately; mem[1]=0 after reset; a load of 0x04 returns 0.
- LATENCY=1 corner:
  - Stimulus: load 0x00 after storing 0x00000055.
  - Required: Ready one cycle after acceptance with Rdata=0x00000055; Stall=1 only in the acceptance cycle.
